// File: rtl/fp8_pkg.sv
// Shared widths, FP16 lane layout and result-entry type for the FP8 vector-multiply result path.
// The entry id field is FP8_ID_W wide; the top's ID_WIDTH must not exceed it.
package fp8_pkg;

  localparam int LANE_W      = 16;
  localparam int RES_W       = 64;
  localparam int LANES       = 4;
  localparam int FP8_MUL_LAT = 3;
  localparam int FP8_ID_W    = 4;

  // FP16 lane: sign [15], exponent [14:10], mantissa [9:0].
  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mant;
  } fp16_t;

  typedef struct packed {
    logic [RES_W-1:0]    data;
    logic [FP8_ID_W-1:0] id;
    logic                mode;
  } res_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head visible combinationally, written entry seen the cycle after push.
// Push when full is dropped unless a pop happens on the same edge; the head holds its last value when empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    head_idx;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When empty, point at the slot just popped so the head output keeps its last value.
  assign head_idx  = empty ? (rd_ptr[AW-1:0] - AW'(1)) : rd_ptr[AW-1:0];
  assign head_data = mem[head_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fp8_vecmul_result_buffer.sv
// Collects results of the non-stalling MUL_LAT-cycle FP8 multiplier into an FWFT FIFO; out_valid rises the cycle after capture.
// issue_ready is a credit (occupancy + in-flight < DEPTH), out_* is valid/ready; FP8_RESBUF_SATCOUNT_EN adds sat_count.
module fp8_vecmul_result_buffer
  import fp8_pkg::*;
#(
  parameter int ID_WIDTH = FP8_ID_W,
  parameter int DEPTH    = 8,
  parameter int MUL_LAT  = FP8_MUL_LAT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic [ID_WIDTH-1:0]    issue_id,
  input  logic                   issue_mode,
  output logic                   issue_ready,
  input  logic [RES_W-1:0]       mul_res,
  input  logic [ID_WIDTH-1:0]    mul_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RES_W-1:0]       out_data,
  output logic [ID_WIDTH-1:0]    out_id,
  output logic                   out_mode,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_err,
  output logic                   tag_err
`ifdef FP8_RESBUF_SATCOUNT_EN
  ,
  output logic [15:0]            sat_count
`endif
);

  logic [MUL_LAT-1:0]    dl_valid;
  logic [MUL_LAT-1:0]    dl_mode;
  logic [ID_WIDTH-1:0]   dl_id [MUL_LAT];
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  accept;
  logic                  capture;
  logic                  pop;
  logic                  wr_ok;
  int                    inflight;
  res_entry_t            wr_entry;
  res_entry_t            head;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight = inflight + int'(dl_valid[i]);
    end
  end

  assign issue_ready = (int'(fifo_count) + inflight) < DEPTH;
  assign accept      = issue_valid && issue_ready && !flush;
  assign capture     = dl_valid[MUL_LAT-1];
  assign pop         = !fifo_empty && out_ready;
  assign wr_ok       = capture && (!fifo_full || pop);

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = mul_res;
    wr_entry.id   = FP8_ID_W'(mul_id);
    wr_entry.mode = dl_mode[MUL_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
      dl_mode  <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        dl_id[i] <= '0;
      end
      drop_err <= 1'b0;
      tag_err  <= 1'b0;
    end else if (flush) begin
      dl_valid <= '0;
      drop_err <= 1'b0;
      tag_err  <= 1'b0;
    end else begin
      dl_valid[0] <= accept;
      dl_id[0]    <= issue_id;
      dl_mode[0]  <= issue_mode;
      for (int i = 1; i < MUL_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_id[i]    <= dl_id[i-1];
        dl_mode[i]  <= dl_mode[i-1];
      end
      // A capture into a full FIFO with no pop only happens if upstream ignored the credit.
      if ((issue_valid && !issue_ready) || (capture && !wr_ok)) begin
        drop_err <= 1'b1;
      end
      if (capture && (mul_id != dl_id[MUL_LAT-1])) begin
        tag_err <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(res_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (capture),
    .push_data (wr_entry),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_id    = ID_WIDTH'(head.id);
  assign out_mode  = head.mode;
  assign count     = fifo_count;

`ifdef FP8_RESBUF_SATCOUNT_EN
  localparam int SLW = $clog2(LANES + 1);

  logic [SLW-1:0] sat_lanes;
  logic [16:0]    sat_sum;
  fp16_t          lane_f;

  always_comb begin
    sat_lanes = '0;
    lane_f    = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_f    = mul_res[l*LANE_W +: LANE_W];
      sat_lanes = sat_lanes + SLW'(lane_f.exp == 5'h1F);
    end
  end

  assign sat_sum = {1'b0, sat_count} + 17'(sat_lanes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (flush) begin
      sat_count <= '0;
    end else if (wr_ok) begin
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fp8_vecmul_result_buffer.sv
// Directed bench for fp8_vecmul_result_buffer: hand-computed expectations, immediate assertions at each check.
// Define FP8_RESBUF_SATCOUNT_EN to also exercise sat_count.
module tb_fp8_vecmul_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_id;
  logic        issue_mode;
  logic        issue_ready;
  logic [63:0] mul_res;
  logic [3:0]  mul_id;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_id;
  logic        out_mode;
  logic [3:0]  count;
  logic        drop_err;
  logic        tag_err;
`ifdef FP8_RESBUF_SATCOUNT_EN
  logic [15:0] sat_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fp8_vecmul_result_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_id    (issue_id),
    .issue_mode  (issue_mode),
    .issue_ready (issue_ready),
    .mul_res     (mul_res),
    .mul_id      (mul_id),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_mode    (out_mode),
    .count       (count),
    .drop_err    (drop_err),
    .tag_err     (tag_err)
`ifdef FP8_RESBUF_SATCOUNT_EN
    ,
    .sat_count   (sat_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int k);
    logic [15:0] v;
    v = 16'(k);
    return {v ^ 16'h1111, v ^ 16'h2222, v ^ 16'h3333, v};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_id = '0; issue_mode = 1'b0;
    mul_res = '0; mul_id = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_count", count, 0);
    check("rst_drop_err", drop_err, 0);
    check("rst_tag_err", tag_err, 0);
    rst_n = 1'b1;
    #1;
    check("rst_issue_ready", issue_ready, 1);
    tick;

    // Single op: issue at edge 0, result presented for edge 3.
    issue_valid = 1'b1; issue_id = 4'd5; issue_mode = 1'b0;
    tick;
    issue_valid = 1'b0;
    tick;
    tick;
    mul_res = 64'h3C00_4000_4200_4400; mul_id = 4'd5;
    check("single_not_early", out_valid, 0);
    tick;
    check("single_out_valid", out_valid, 1);
    check("single_out_data", out_data, 64'h3C00_4000_4200_4400);
    check("single_out_id", out_id, 5);
    check("single_out_mode", out_mode, 0);
    check("single_count", count, 1);
    check("single_tag_err", tag_err, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("single_pop_count", count, 0);
    check("single_pop_valid", out_valid, 0);
    check("single_hold_data", out_data, 64'h3C00_4000_4200_4400);

    // Fill: 8 back-to-back issues, 9th is refused.
    for (int e = 0; e <= 10; e++) begin
      issue_valid = (e <= 8);
      issue_id    = 4'(e);
      issue_mode  = e[0];
      if (e >= 3) begin
        mul_id  = 4'(e - 3);
        mul_res = pat(e - 3);
      end
      if (e <= 8) check($sformatf("fill_ready_%0d", e), issue_ready, (e < 8));
      if (e == 8) check("fill_drop_before", drop_err, 0);
      tick;
    end
    issue_valid = 1'b0;
    check("fill_count", count, 8);
    check("fill_drop_err", drop_err, 1);
    check("fill_tag_err", tag_err, 0);
    check("fill_ready_low", issue_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_valid_%0d", k), out_valid, 1);
      check($sformatf("drain_id_%0d", k), out_id, k);
      check($sformatf("drain_data_%0d", k), out_data, pat(k));
      check($sformatf("drain_mode_%0d", k), out_mode, k % 2);
      tick;
    end
    out_ready = 1'b0;
    check("drain_count", count, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_drop_err", drop_err, 0);

    // Streaming: IDs 0..15 with out_ready held high.
    out_ready = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      issue_valid = (e < 16);
      issue_id    = 4'(e);
      issue_mode  = e[1];
      if (e >= 3) begin
        mul_id  = 4'(e - 3);
        mul_res = pat(e + 100);
      end
      if (e < 16) check($sformatf("stream_ready_%0d", e), issue_ready, 1);
      tick;
      if (e >= 3) begin
        check($sformatf("stream_valid_%0d", e), out_valid, 1);
        check($sformatf("stream_id_%0d", e), out_id, e - 3);
        check($sformatf("stream_data_%0d", e), out_data, pat(e + 100));
        check($sformatf("stream_mode_%0d", e), out_mode, ((e - 3) >> 1) % 2);
        check($sformatf("stream_count_%0d", e), count, 1);
      end
    end
    issue_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    check("stream_end_count", count, 0);
    check("stream_tag_err", tag_err, 0);
    check("stream_drop_err", drop_err, 0);

    // Tag mismatch: issued id 2, multiplier reports 3.
    issue_valid = 1'b1; issue_id = 4'd2; issue_mode = 1'b1;
    tick;
    issue_valid = 1'b0;
    tick;
    tick;
    mul_id = 4'd3; mul_res = pat(2);
    tick;
    check("tag_err_set", tag_err, 1);
    check("tag_out_id", out_id, 3);
    check("tag_out_mode", out_mode, 1);
    check("tag_out_valid", out_valid, 1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("tag_flush_err", tag_err, 0);
    check("tag_flush_count", count, 0);
    check("tag_flush_valid", out_valid, 0);

    // Async reset with 3 entries stored and 2 in flight.
    for (int e = 0; e <= 5; e++) begin
      issue_valid = (e < 5);
      issue_id    = 4'(8 + e);
      issue_mode  = 1'b0;
      if (e >= 3) begin
        mul_id  = 4'(8 + e - 3);
        mul_res = pat(e + 200);
      end
      tick;
    end
    issue_valid = 1'b0;
    check("pre_reset_count", count, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_count", count, 0);
    check("areset_valid", out_valid, 0);
    check("areset_data", out_data, 0);
    check("areset_id", out_id, 0);
    #2;
    rst_n = 1'b1;
    for (int e = 0; e < 5; e++) begin
      mul_id  = 4'(11 + e);
      mul_res = pat(e + 300);
      tick;
      check($sformatf("post_reset_valid_%0d", e), out_valid, 0);
    end
    check("post_reset_count", count, 0);
    check("post_reset_ready", issue_ready, 1);

`ifdef FP8_RESBUF_SATCOUNT_EN
    check("sat_reset", sat_count, 0);
    issue_valid = 1'b1; issue_id = 4'd1; issue_mode = 1'b0;
    tick;
    issue_valid = 1'b0;
    tick;
    tick;
    mul_id = 4'd1; mul_res = {16'h7C00, 16'hFC00, 16'h3C00, 16'h7FFC};
    tick;
    check("sat_count_3", sat_count, 3);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("sat_flush", sat_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fp8_vecmul_result_buffer.md
Name: fp8_vecmul_result_buffer

Overview:
- Downstream collector for the 3-cycle FP8 vector-multiply pipe, which has no stall capability.
- Tracks issued operations through a valid/tag delay line matched to the multiplier latency.
- Captures each 64-bit result (four FP16 lanes) with its ID and mode into a FIFO.
- Presents entries on a valid/ready output; exports an issue credit so the upstream issuer never overruns the FIFO.

Parameters:
- ID_WIDTH, 4: width of operation tag.
- DEPTH, 8: FIFO entries; power of two, >= 4.
- MUL_LAT, 3: multiplier latency in cycles, from issue to res/id_out valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO, delay line and status
- issue_valid  in  1  upstream presents an op to the multiplier this cycle
- issue_id  in  ID_WIDTH  tag of the issued op
- issue_mode  in  1  e5m2mode of the issued op
- issue_ready  out  1  credit available; issue is accepted only when both valid and ready
- mul_res  in  64  multiplier result {qd,qc,qb,qa}
- mul_id  in  ID_WIDTH  multiplier id_out
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  64  head result
- out_id  out  ID_WIDTH  head tag
- out_mode  out  1  head mode
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_err  out  1  sticky: issue_valid seen while issue_ready low
- tag_err  out  1  sticky: mul_id differs from expected tag at capture

Behaviour:
- Reset (rst_n low, async):
  - Delay line cleared; FIFO empty; pointers 0.
  - out_valid=0, out_data=0, out_id=0, out_mode=0, count=0, drop_err=0, tag_err=0.
  - issue_ready=1 after reset deasserts.
  - Reset mid-operation discards all in-flight ops.
- Delay line:
  - MUL_LAT stages of {valid, id, mode}.
  - Stage 0 loads {issue_valid&issue_ready, issue_id, issue_mode}.
- Capture:
  - When the last stage is valid at a rising edge, write {mul_res, mul_id, mode} into the FIFO.
  - Op issued at edge T is written at edge T+MUL_LAT; out_valid can rise in the cycle after edge T+MUL_LAT.
- issue_ready = (count + inflight) < DEPTH.
  - inflight = number of valid delay-line stages.
  - Combinational from registered state only; no path from issue_valid.
- Drop rule:
  - issue_valid while issue_ready=0: op not tracked, drop_err set.
  - Upstream still drives the multiplier; its result is ignored.
- Tag check: at capture, mul_id != stored id sets tag_err; the entry is still written, with mul_id.
- FIFO:
  - First-word-fall-through; out_* reflect the head entry combinationally from storage.
  - Pop on out_valid&out_ready.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Full = MSBs differ and low bits equal; empty = pointers equal.
- Simultaneous push and pop: allowed at any occupancy, including full (credits guarantee a push never arrives when full without a pop). count unchanged.
- Full-and-no-pop with capture pending cannot occur by construction. If it does (credit bypass), discard the write and set drop_err.
- flush:
  - Highest priority after reset.
  - Next edge: FIFO empty, delay line invalid, drop_err=0, tag_err=0.
  - issue_valid in the flush cycle is not tracked.
- out_data/out_id/out_mode hold the last head value when empty; consumers qualify with out_valid.

Optional Feature:
- Macro: FP8_RESBUF_SATCOUNT_EN.
- When defined:
  - Extra output sat_count [15:0].
  - At each capture, adds the number of lanes whose exponent field (lane bits [14:10]) equals 5'b11111.
  - Saturates at 16'hFFFF; cleared by reset and flush.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package fp8_pkg holds:
  - LANE_W=16, RES_W=64, LANES=4, FP8_MUL_LAT=3.
  - Lane field offsets: sign 15, exp 14:10, mant 9:0.
  - Result-entry struct {data, id, mode}.
- One sub-module: sync_fifo_fwft, parameterised width and depth, exposing push/pop/full/empty/count.
- Delay line, credit logic and error flags live in the top module.

Test Plan:
- Single op: issue id=5, mode=0 at edge 0; mul_res=64'h3C00_4000_4200_4400, mul_id=5 at edge 3 -> out_valid in cycle after edge 3; out_data matches, out_id=5, count=1; pop -> count=0.
- Fill: issue 8 ops back-to-back (DEPTH=8) with out_ready=0 -> issue_ready drops after 8th issue; 9th issue_valid sets drop_err; count reaches 8; no tag_err.
- Streaming: continuous issue with out_ready=1 -> issue_ready stays 1; IDs 0..15 emerge in order at one per cycle after latency 3.
- Tag mismatch: issue id=2; drive mul_id=3 at capture -> tag_err=1, entry out_id=3; flush -> tag_err=0, count=0, out_valid=0.
- Async reset: assert rst_n low mid-stream with 3 entries and 2 in flight, between clock edges -> outputs clear immediately; after release, no stale entries appear.
- With FP8_RESBUF_SATCOUNT_EN: capture mul_res with lanes 16'h7C00,16'hFC00,16'h3C00,16'h7FFC -> sat_count=3.
